// File: rtl/dbg_display_pager.sv
// dbg_display_pager: pages through a frozen-or-live bank of debug words on active-low 7-segment digits
module dbg_display_pager #(
    parameter int NUM_WORDS    = 4,
    parameter int WORD_W       = 16,
    parameter int SHOW_WORDS   = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [NUM_WORDS*WORD_W-1:0]       i_words,
    input  logic                              i_btnNext,
    input  logic                              i_btnPrev,
    input  logic                              i_freeze,
    output logic [SHOW_WORDS*WORD_W/4*7-1:0]  o_segControls,
    output logic [$clog2(NUM_WORDS)-1:0]      o_page,
    output logic                              o_pageChg
);
    localparam int PW  = $clog2(NUM_WORDS);
    localparam int CW  = $clog2(DEBOUNCE_CYC);
    localparam int NIB = WORD_W / 4;
    localparam int SW  = SHOW_WORDS * NIB * 7;

    logic [1:0]                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]                  db_q, db_d, dbp_q, dbp_d;
    logic [CW-1:0]               cnt_q [2];
    logic [CW-1:0]               cnt_d [2];
    logic [PW-1:0]               page_q, page_d;
    logic                        chg_q, chg_d;
    logic [NUM_WORDS*WORD_W-1:0] snap_q, snap_d;
    logic [SW-1:0]               seg_q, seg_d;
    logic [1:0]                  press;
    logic                        go_next, go_prev;
    logic [WORD_W-1:0]           word;
    int                          idx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Synchronise and debounce both buttons; bit 0 is next, bit 1 is prev
    always_comb begin
        sync1_d = {i_btnPrev, i_btnNext};
        sync2_d = sync1_q;
        dbp_d   = db_q;
        db_d    = db_q;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != db_q[b]) begin
                if (cnt_q[b] == CW'(DEBOUNCE_CYC - 1))
                    db_d[b] = sync2_q[b];
                else
                    cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    // Page register update from registered press edges; simultaneous presses cancel
    always_comb begin
        press   = db_q & ~dbp_q;
        go_next = press[0] & ~press[1];
        go_prev = press[1] & ~press[0];
        page_d  = go_next ? ((page_q == PW'(NUM_WORDS - 1)) ? '0 : page_q + PW'(1)) :
                  go_prev ? ((page_q == '0) ? PW'(NUM_WORDS - 1) : page_q - PW'(1)) : page_q;
        chg_d   = go_next | go_prev;
        snap_d  = i_freeze ? snap_q : i_words;
    end

    // Map snapshot words starting at the current page onto the display slots
    always_comb begin
        seg_d = '1;
        word  = '0;
        idx   = 0;
        for (int k = 0; k < SHOW_WORDS; k++) begin
            idx  = (int'(page_q) + k) % NUM_WORDS;
            word = snap_q[idx*WORD_W +: WORD_W];
            for (int j = 0; j < NIB; j++)
                seg_d[(k*NIB + j)*7 +: 7] = hex7(word[j*4 +: 4]);
        end
    end

    // State registers; display blanks during reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            dbp_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            page_q   <= '0;
            chg_q    <= 1'b0;
            snap_q   <= '0;
            seg_q    <= '1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            dbp_q    <= dbp_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            page_q   <= page_d;
            chg_q    <= chg_d;
            snap_q   <= snap_d;
            seg_q    <= seg_d;
        end
    end

    assign o_segControls = seg_q;
    assign o_page        = page_q;
    assign o_pageChg     = chg_q;
endmodule

// File: tb/tb_dbg_display_pager.sv
// tb_dbg_display_pager: randomized and directed checks of the pager against a behavioural model
module tb_dbg_display_pager;
    localparam int NW = 4;
    localparam int WW = 16;
    localparam int SWD = 2;
    localparam int D = 16;
    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 0;
    logic        rstn = 0;
    logic [63:0] words = 0;
    logic        bn = 0, bp = 0, frz = 0;
    logic [55:0] seg;
    logic [1:0]  page;
    logic        chg;

    int errors = 0, checks = 0, pulses = 0;

    int          mpage;
    logic        mchg;
    logic [63:0] msnap;
    logic [55:0] mseg;
    logic [1:0]  rawh [2];
    logic [D-1:0] shv [2];
    int          hn [2];
    logic        mdb [2];
    logic        rise [2];

    dbg_display_pager #(.NUM_WORDS(NW), .WORD_W(WW), .SHOW_WORDS(SWD), .DEBOUNCE_CYC(D)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_words(words), .i_btnNext(bn), .i_btnPrev(bp),
        .i_freeze(frz), .o_segControls(seg), .o_page(page), .o_pageChg(chg));

    always #5 clk = ~clk;

    function automatic logic [27:0] segw(input logic [15:0] w);
        logic [27:0] r;
        for (int j = 0; j < 4; j++) r[j*7 +: 7] = HEX[w[j*4 +: 4]];
        return r;
    endfunction

    function automatic logic [55:0] segs_of(input int pg, input logic [63:0] sn);
        logic [55:0] r;
        for (int k = 0; k < SWD; k++) r[k*28 +: 28] = segw(sn[((pg + k) % NW)*16 +: 16]);
        return r;
    endfunction

    // Behavioural model: a button level is accepted after D consecutive synced samples differ from it
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mpage = 0;
            mchg  = 0;
            msnap = 0;
            mseg  = '1;
            for (int b = 0; b < 2; b++) begin
                rawh[b] = 0; shv[b] = 0; hn[b] = 0; mdb[b] = 0; rise[b] = 0;
            end
        end else begin
            logic s;
            logic [1:0] btn;
            btn   = {bp, bn};
            mseg  = segs_of(mpage, msnap);
            mchg  = rise[0] != rise[1];
            if (rise[0] && !rise[1]) mpage = (mpage + 1) % NW;
            else if (rise[1] && !rise[0]) mpage = (mpage + NW - 1) % NW;
            if (!frz) msnap = words;
            for (int b = 0; b < 2; b++) begin
                s       = rawh[b][1];
                rawh[b] = {rawh[b][0], btn[b]};
                shv[b]  = {shv[b][D-2:0], s};
                hn[b]   = hn[b] + 1;
                rise[b] = 0;
                if (hn[b] >= D && shv[b] == {D{!mdb[b]}}) begin
                    mdb[b]  = s;
                    rise[b] = s;
                    hn[b]   = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("page", 64'(page), 64'(mpage));
            chk("chg", 64'(chg), 64'(mchg));
            chk("seg", 64'(seg), 64'(mseg));
            pulses += int'(chg);
        end
    endtask

    task automatic press(input logic nx, input logic pv);
        bn = nx; bp = pv;
        tick(25);
        bn = 0; bp = 0;
        tick(25);
    endtask

    initial begin
        int exp_pg;
        int rem [2];
        words = {16'h8000, 16'h0F0F, 16'hABCD, 16'h1234};
        tick(3);
        chk("rst_seg", 64'(seg), {8'h0, {56{1'b1}}});
        chk("rst_page", 64'(page), 0);
        chk("rst_chg", 64'(chg), 0);
        rstn = 1;
        tick(2);
        chk("init_lo", 64'(seg[27:0]), 64'({HEX[1], HEX[2], HEX[3], HEX[4]}));
        chk("init_hi", 64'(seg[55:28]), 64'({HEX[10], HEX[11], HEX[12], HEX[13]}));

        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            bn = (i % 2 == 0);
            tick(5);
        end
        bn = 1;
        for (int t = 1; t <= 19; t++) begin
            tick();
            if (t == 18) chk("bounce_pre", 64'(page), 0);
            if (t == 19) chk("bounce_pg", 64'(page), 1);
        end
        chk("bounce_pulses", pulses, 1);
        tick();
        chk("bounce_slot0", 64'(seg[27:0]), 64'(segw(16'hABCD)));
        bn = 0;
        tick(25);

        press(0, 1);
        chk("back_to_0", 64'(page), 0);
        exp_pg = 0;
        for (int i = 0; i < 4; i++) begin
            press(1, 0);
            exp_pg = (exp_pg + 1) % NW;
            chk("wrap_pg", 64'(page), 64'(exp_pg));
            if (exp_pg == 3) begin
                chk("pg3_slot0", 64'(seg[27:0]), 64'(segw(16'h8000)));
                chk("pg3_slot1", 64'(seg[55:28]), 64'(segw(16'h1234)));
            end
        end
        press(0, 1);
        chk("prev_wrap", 64'(page), 3);

        pulses = 0;
        bn = 1; bp = 1;
        tick(30);
        bn = 0; bp = 0;
        tick(25);
        chk("both_pulses", pulses, 0);
        chk("both_page", 64'(page), 3);

        press(1, 0);
        chk("to_0", 64'(page), 0);
        frz = 1;
        tick();
        words[15:0] = 16'hFFFF;
        tick(4);
        chk("frozen", 64'(seg[27:0]), 64'(segw(16'h1234)));
        frz = 0;
        tick(2);
        chk("unfrozen", 64'(seg[27:0]), 64'(segw(16'hFFFF)));

        press(1, 0);
        press(1, 0);
        chk("pg2", 64'(page), 2);
        bn = 1;
        tick(10);
        rstn = 0;
        tick(3);
        chk("mid_rst_pg", 64'(page), 0);
        rstn = 1;
        for (int t = 1; t <= 19; t++) begin
            tick();
            if (t == 18) chk("held_pre", 64'(page), 0);
            if (t == 19) chk("held_pg", 64'(page), 1);
        end
        bn = 0;
        tick(25);

        rem[0] = 1; rem[1] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    if (b == 0) bn = ~bn; else bp = ~bp;
                    rem[b] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : int'($urandom_range(20, 60));
                end
            end
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 7) == 0) words[w*16 +: 16] = 16'($urandom);
            if ($urandom_range(0, 49) == 0) frz = ~frz;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
